// File: rtl/serial_link_fifo_bridge.sv
// Buffered bridge between the CPU PIO side and the character serializer/deserializer:
// TX FIFO drained by a pacing FSM (gap + sent-timeout), RX FIFO filled per received character.
module serial_link_fifo_bridge #(
    parameter int DATA_W         = 8,
    parameter int TX_DEPTH       = 16,
    parameter int RX_DEPTH       = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        tx_wr_en,
    input  logic [DATA_W-1:0]           tx_wr_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        tx_busy,
    output logic                        ser_load,
    output logic [DATA_W-1:0]           ser_tx_data,
    input  logic                        ser_char_sent,
    input  logic                        ser_char_rcvd,
    input  logic [DATA_W-1:0]           ser_rx_data,
    input  logic                        rx_rd_en,
    output logic [DATA_W-1:0]           rx_rd_data,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic                        err_clr,
    output logic                        tx_overflow,
    output logic                        rx_overflow,
    output logic                        tx_timeout
);

    localparam int TX_AW   = $clog2(TX_DEPTH);
    localparam int RX_AW   = $clog2(RX_DEPTH);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_GAP} state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;

    logic [DATA_W-1:0]  tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]   tx_wr_ptr, tx_rd_ptr;
    logic               tx_push, tx_pop;

    logic [DATA_W-1:0]  rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]   rx_wr_ptr, rx_rd_ptr;
    logic               rx_push, rx_pop, rx_full;

    // The FSM pops on the edge that takes it from IDLE into LOAD, so ser_load and the popped head line up.
    assign tx_pop   = (state == ST_IDLE) && (tx_count != '0);
    assign tx_full  = (tx_count == (TX_AW + 1)'(TX_DEPTH));
    assign tx_push  = tx_wr_en && (!tx_full || tx_pop);
    assign tx_busy  = (state != ST_IDLE);

    assign rx_full    = (rx_count == (RX_AW + 1)'(RX_DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_pop     = rx_rd_en && !rx_empty;
    assign rx_push    = ser_char_rcvd && (!rx_full || rx_pop);
    assign rx_rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    always_ff @(posedge clk_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= ser_rx_data;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TX_AW + 1)'(1);
                2'b01:   tx_count <= tx_count - (TX_AW + 1)'(1);
                default: tx_count <= tx_count;
            endcase
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RX_AW + 1)'(1);
                2'b01:   rx_count <= rx_count - (RX_AW + 1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_overflow <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            tx_overflow <= (tx_wr_en && tx_full && !tx_pop) || (tx_overflow && !err_clr);
            rx_overflow <= (ser_char_rcvd && rx_full && !rx_pop) || (rx_overflow && !err_clr);
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            ser_load    <= 1'b0;
            ser_tx_data <= '0;
            tx_timeout  <= 1'b0;
        end else begin
            ser_load   <= 1'b0;
            tx_timeout <= tx_timeout && !err_clr;
            case (state)
                ST_IDLE: begin
                    if (tx_count != '0) begin
                        state       <= ST_LOAD;
                        ser_load    <= 1'b1;
                        ser_tx_data <= tx_mem[tx_rd_ptr];
                    end
                end
                ST_LOAD: begin
                    state <= ST_WAIT;
                    timer <= '0;
                end
                ST_WAIT: begin
                    if (ser_char_sent) begin
                        timer <= '0;
                        state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if (timer == TO_LAST) begin
                        tx_timeout <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    if (timer == GAP_LAST) state <= ST_IDLE;
                    else                   timer <= timer + TMR_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_link_fifo_bridge.sv
// Randomized and directed bench for serial_link_fifo_bridge against a queue/timestamp reference model.
module tb_serial_link_fifo_bridge;
    localparam int DW  = 8;
    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam int GAP = 4;
    localparam int TO  = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_wr_en = 1'b0, ser_char_sent = 1'b0, ser_char_rcvd = 1'b0;
    logic          rx_rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] tx_wr_data = '0, ser_rx_data = '0;
    logic          tx_full, tx_busy, ser_load, rx_empty, tx_overflow, rx_overflow, tx_timeout;
    logic [4:0]    tx_count, rx_count;
    logic [DW-1:0] ser_tx_data, rx_rd_data;

    always #5 clk = ~clk;

    serial_link_fifo_bridge #(
        .DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_count(tx_count),
        .tx_busy(tx_busy), .ser_load(ser_load), .ser_tx_data(ser_tx_data),
        .ser_char_sent(ser_char_sent), .ser_char_rcvd(ser_char_rcvd), .ser_rx_data(ser_rx_data),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .err_clr(err_clr), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow), .tx_timeout(tx_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queues for FIFO contents, cycle stamps for the pacing rules.
    logic [DW-1:0] m_txq[$];
    logic [DW-1:0] m_rxq[$];
    int            cyc = 0, idle_from = 0, load_at = -100, ack_dly = 0;
    bit            inflight = 0, rnd_ack = 0;
    bit            m_load = 0, m_txov = 0, m_rxov = 0, m_to = 0;
    logic [DW-1:0] m_txd = '0;

    // Per-cycle stimulus (cleared after each step).
    bit            s_wr, s_sent_x, s_rcvd, s_rd, s_clr;
    logic [DW-1:0] s_wd, s_rxd;

    int last_load_obs = -100;
    bit prev_to = 0;

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        inflight  = 0;
        idle_from = cyc;
        m_load = 0; m_txov = 0; m_rxov = 0; m_to = 0;
        m_txd = '0;
    endtask

    task automatic compare();
        chk("ser_load",    ser_load,    m_load);
        chk("ser_tx_data", ser_tx_data, m_txd);
        chk("tx_count",    tx_count,    m_txq.size());
        chk("tx_full",     tx_full,     m_txq.size() == TXD);
        chk("tx_busy",     tx_busy,     inflight || (cyc < idle_from));
        chk("tx_overflow", tx_overflow, m_txov);
        chk("tx_timeout",  tx_timeout,  m_to);
        chk("rx_count",    rx_count,    m_rxq.size());
        chk("rx_empty",    rx_empty,    m_rxq.size() == 0);
        chk("rx_rd_data",  rx_rd_data,  (m_rxq.size() > 0) ? m_rxq[0] : 8'h00);
        chk("rx_overflow", rx_overflow, m_rxov);
    endtask

    task automatic step();
        bit sent, pop, tx_ov, to_set, rpop, rx_ov;
        sent = s_sent_x || (inflight && ack_dly > 0 && cyc == load_at + ack_dly);
        tx_wr_en = s_wr; tx_wr_data = s_wd; ser_char_sent = sent;
        ser_char_rcvd = s_rcvd; ser_rx_data = s_rxd; rx_rd_en = s_rd; err_clr = s_clr;

        pop    = !inflight && cyc >= idle_from && m_txq.size() > 0;
        tx_ov  = s_wr && m_txq.size() == TXD && !pop;
        to_set = 0;
        if (inflight && cyc >= load_at + 1) begin
            if (sent) begin
                inflight  = 0;
                idle_from = cyc + 1 + GAP;
            end else if (cyc == load_at + TO) begin
                to_set    = 1;
                inflight  = 0;
                idle_from = cyc + 1;
            end
        end
        m_load = pop;
        if (pop) begin
            m_txd    = m_txq.pop_front();
            inflight = 1;
            load_at  = cyc + 1;
            if (rnd_ack)
                ack_dly = ($urandom_range(0, 39) == 0) ? TO + int'($urandom_range(0, 1))
                                                       : int'($urandom_range(1, 6));
        end
        if (s_wr && !tx_ov) m_txq.push_back(s_wd);
        m_txov = tx_ov  || (m_txov && !s_clr);
        m_to   = to_set || (m_to && !s_clr);

        rpop  = s_rd && m_rxq.size() > 0;
        rx_ov = s_rcvd && m_rxq.size() == RXD && !rpop;
        if (rpop) void'(m_rxq.pop_front());
        if (s_rcvd && !rx_ov) m_rxq.push_back(s_rxd);
        m_rxov = rx_ov || (m_rxov && !s_clr);
        cyc++;

        @(posedge clk);
        @(negedge clk);
        compare();
        if (ser_load) begin
            chk("load_gap", (cyc - last_load_obs) >= GAP + 1, 1'b1);
            last_load_obs = cyc;
        end
        if (tx_timeout && !prev_to) chk("to_latency", cyc - last_load_obs, TO + 1);
        prev_to = tx_timeout;
        s_wr = 0; s_sent_x = 0; s_rcvd = 0; s_rd = 0; s_clr = 0; s_wd = '0; s_rxd = '0;
    endtask

    initial begin
        s_wr = 0; s_sent_x = 0; s_rcvd = 0; s_rd = 0; s_clr = 0; s_wd = '0; s_rxd = '0;
        repeat (3) @(negedge clk);
        compare();
        rst = 1'b0;

        // Three back-to-back writes, each acknowledged three clocks after its load.
        ack_dly = 3;
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_wd = 8'h41 + DW'(i); step();
        end
        repeat (40) step();
        chk("busy_after_burst", tx_busy, 1'b0);

        // Stalled serializer: 18 writes, the last overflows; then clear and drain.
        ack_dly = 0;
        for (int i = 0; i < 18; i++) begin
            s_wr = 1; s_wd = DW'($urandom); step();
        end
        chk("tx_full_stalled", tx_full, 1'b1);
        chk("tx_ovf_set", tx_overflow, 1'b1);
        s_clr = 1; step();
        chk("tx_ovf_clr", tx_overflow, 1'b0);
        s_sent_x = 1; step();
        ack_dly = 2;
        repeat (250) step();

        // Unacknowledged character times out, queued one follows.
        ack_dly = 0;
        s_wr = 1; s_wd = 8'h55; step();
        s_wr = 1; s_wd = 8'h66; step();
        repeat (TO + 4) step();
        chk("tx_timeout_set", tx_timeout, 1'b1);
        ack_dly = 2;
        s_clr = 1; step();
        repeat (20) step();

        // RX fill, overflow, push-with-pop, drain past empty.
        for (int i = 0; i < 16; i++) begin
            s_rcvd = 1; s_rxd = DW'(i); step();
        end
        chk("rx_full_head", rx_rd_data, 8'h00);
        s_rcvd = 1; s_rxd = 8'hAA; step();
        chk("rx_ovf_set", rx_overflow, 1'b1);
        s_rcvd = 1; s_rxd = 8'h10; s_rd = 1; step();
        chk("rx_count_pushpop", rx_count, 16);
        for (int i = 0; i < 20; i++) begin
            s_rd = 1; step();
        end
        s_clr = 1; step();

        // Random traffic.
        rnd_ack = 1;
        for (int i = 0; i < 3000; i++) begin
            s_wr     = ($urandom_range(0, 2) == 0);
            s_wd     = DW'($urandom);
            s_rcvd   = ($urandom_range(0, 2) == 0);
            s_rxd    = DW'($urandom);
            s_rd     = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            s_clr    = ($urandom_range(0, 39) == 0);
            s_sent_x = ($urandom_range(0, 63) == 0);
            step();
        end
        rnd_ack = 0;

        // Asynchronous reset during WAIT with both FIFOs populated.
        ack_dly = 0;
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_wd = 8'hC0 + DW'(i); s_rcvd = 1; s_rxd = 8'h30 + DW'(i); step();
        end
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        compare();
        rst = 1'b0;
        repeat (20) step();
        chk("no_load_after_reset", ser_load, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
